// File: rtl/scan_display_ctrl.sv
// Debug-channel display controller: selects one of NUM_CH channels, shows it
// in hex or unsigned decimal (sequential double-dabble) on a time-multiplexed
// bank of NUM_DIGITS active-low 7-segment digits.
module scan_display_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int NUM_CH     = 4,
   parameter int SEL_W      = 2,
   parameter int SCAN_DIV   = 100000
) (
   input  logic                             sysclk,
   input  logic                             reset,
   input  logic [NUM_CH*4*NUM_DIGITS-1:0]   ch_data,
   input  logic [SEL_W-1:0]                 sel,
   input  logic                             dec_mode,
   input  logic                             blank_lz,
   output logic [6:0]                       bcd7,
   output logic [NUM_DIGITS-1:0]            an,
   output logic                             busy,
   output logic                             overflow
);

   localparam int W     = 4*NUM_DIGITS;
   localparam int CNT_W = $clog2(W);
   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

   state_t              state_q, state_d;
   logic [W-1:0]        snap_q, snap_d;        // snapshot; shifted out MSB-first in decimal mode
   logic                mode_q, mode_d;        // decimal mode latched with the snapshot
   logic [W-1:0]        bcd_q, bcd_d;          // BCD accumulator
   logic                ovf_q, ovf_d;          // sticky overflow of the running conversion
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [W-1:0]        disp_q, disp_d;        // committed display nibbles
   logic                disp_ovf_q, disp_ovf_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                load_q, load_d;        // a new digit slot starts this cycle
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]          seg_q, seg_d;

   logic [W-1:0]        sel_data;
   logic [W-1:0]        adj;
   logic [W-1:0]        hi;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
         4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
         4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
         4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
         4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
         4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
         4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
         4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
      endcase
   endfunction

   // Channel mux; out-of-range select values read as zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel == SEL_W'(k)) sel_data = ch_data[k*W +: W];
      end
   end

   // Conversion FSM: next state, snapshot, double-dabble step and atomic commit.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      snap_d     = snap_q;
      mode_d     = mode_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      bit_cnt_d  = bit_cnt_q;
      disp_d     = disp_q;
      disp_ovf_d = disp_ovf_q;
      adj        = bcd_q;
      case (state_q)
         ST_IDLE: begin
            snap_d    = sel_data;
            mode_d    = dec_mode;
            bcd_d     = '0;
            ovf_d     = 1'b0;
            bit_cnt_d = '0;
            state_d   = dec_mode ? ST_SHIFT : ST_COMMIT;
         end
         ST_SHIFT: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
            ovf_d     = ovf_q | adj[W-1];
            bcd_d     = {adj[W-2:0], snap_q[W-1]};
            snap_d    = {snap_q[W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(W-1)) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (bcd_d[4*i +: 4] >= 4'd10) ovf_d = 1'b1;
               end
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            disp_d     = mode_q ? bcd_q : snap_q;
            disp_ovf_d = mode_q & ovf_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Scan timing and per-slot segment/anode registration (stable within a slot).
   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      idx_d     = idx_q;
      load_d    = 1'b0;
      an_d      = an_q;
      seg_d     = seg_q;
      hi        = disp_q >> {idx_q, 2'b00};
      if (div_cnt_q == DIV_W'(SCAN_DIV-1)) begin
         div_cnt_d = '0;
         load_d    = 1'b1;
         idx_d     = (idx_q == IDX_W'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
      end
      if (load_q) begin
         an_d = ~(NUM_DIGITS'(1) << idx_q);
         if (disp_ovf_q)
            seg_d = 7'h3F;
         else if (blank_lz && (idx_q != '0) && (hi == '0))
            seg_d = 7'h7F;
         else
            seg_d = hex_seg(hi[3:0]);
      end
   end

   // State registers; reset abandons any conversion and blanks the display.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         snap_q     <= '0;
         mode_q     <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         bit_cnt_q  <= '0;
         disp_q     <= '0;
         disp_ovf_q <= 1'b0;
         div_cnt_q  <= '0;
         idx_q      <= '0;
         load_q     <= 1'b1;
         an_q       <= '1;
         seg_q      <= 7'h7F;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         snap_q     <= snap_d;
         mode_q     <= mode_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         bit_cnt_q  <= bit_cnt_d;
         disp_q     <= disp_d;
         disp_ovf_q <= disp_ovf_d;
         div_cnt_q  <= div_cnt_d;
         idx_q      <= idx_d;
         load_q     <= load_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign bcd7     = seg_q;
   assign an       = an_q;
   assign busy     = (state_q == ST_SHIFT);
   assign overflow = disp_ovf_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Randomised and directed bench for scan_display_ctrl, checked against a
// digit-level arithmetic model of what each display position should show.
module tb_scan_display_ctrl;

   logic        sysclk = 1'b0;
   logic        reset;
   logic [15:0] ch [4];
   logic [63:0] ch_data;
   logic [1:0]  sel;
   logic        dec_mode;
   logic        blank_lz;
   logic [6:0]  bcd7;
   logic [3:0]  an;
   logic        busy;
   logic        overflow;

   logic [47:0] ch_data3;
   logic [1:0]  sel3;
   logic [6:0]  bcd7_3;
   logic [3:0]  an3;
   logic        busy3;
   logic        overflow3;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   assign ch_data = {ch[3], ch[2], ch[1], ch[0]};

   always #5 sysclk = ~sysclk;

   scan_display_ctrl #(.NUM_DIGITS(4), .NUM_CH(4), .SEL_W(2), .SCAN_DIV(4)) u_dut (
      .sysclk(sysclk), .reset(reset), .ch_data(ch_data), .sel(sel),
      .dec_mode(dec_mode), .blank_lz(blank_lz), .bcd7(bcd7), .an(an),
      .busy(busy), .overflow(overflow));

   scan_display_ctrl #(.NUM_DIGITS(4), .NUM_CH(3), .SEL_W(2), .SCAN_DIV(4)) u_dut3 (
      .sysclk(sysclk), .reset(reset), .ch_data(ch_data3), .sel(sel3),
      .dec_mode(1'b0), .blank_lz(1'b0), .bcd7(bcd7_3), .an(an3),
      .busy(busy3), .overflow(overflow3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // What digit idx should show for value v, from place-value arithmetic.
   function automatic logic [6:0] exp_seg(input int unsigned v, input bit dec,
                                          input bit blank, input int idx);
      int unsigned base = dec ? 10 : 16;
      int unsigned p = 1;
      for (int i = 0; i < idx; i++) p = p * base;
      if (dec && v > 9999) return 7'h3F;
      if (blank && idx != 0 && v < p) return 7'h7F;
      return seg_tbl[(v / p) % base];
   endfunction

   function automatic int unsigned chan_val(input int s);
      return (s < 4) ? int'(ch[s]) : 0;
   endfunction

   task automatic settle();
      repeat (45) @(negedge sysclk);
   endtask

   // Watch the scan for ncyc cycles; each lit digit must match the model.
   task automatic check_window(input string tag, input int unsigned v, input bit dec,
                               input bit blank, input int ncyc, input bit use3);
      logic [3:0] seen = '0;
      logic [3:0] a, m;
      logic [6:0] s;
      int idx;
      repeat (ncyc) begin
         @(negedge sysclk);
         a = use3 ? an3 : an;
         s = use3 ? bcd7_3 : bcd7;
         idx = -1;
         for (int i = 0; i < 4; i++) begin
            m = 4'b0001 << i;
            if (a == ~m) idx = i;
         end
         check({tag, "_onehot"}, 32'(idx >= 0), 32'd1);
         if (idx >= 0) begin
            check({tag, "_seg"}, 32'(s), 32'(exp_seg(v, dec, blank, idx)));
            seen[idx] = 1'b1;
         end
      end
      if (ncyc >= 16) check({tag, "_seen"}, 32'(seen), 32'hF);
   endtask

   task automatic wait_busy(input logic level, input string tag);
      int n = 0;
      while (busy !== level && n < 100) begin
         @(negedge sysclk);
         n++;
      end
      check(tag, 32'(busy), 32'(level));
   endtask

   initial begin
      int unsigned v;
      int cnt;
      logic [15:0] edge_vals [6] = '{16'd0, 16'd9, 16'd10, 16'd9999, 16'd10000, 16'd65535};

      reset = 1'b0;
      for (int k = 0; k < 4; k++) ch[k] = '0;
      sel = 2'd0; dec_mode = 1'b0; blank_lz = 1'b0;
      ch_data3 = {16'h1357, 16'h2468, 16'hBEEF};
      sel3 = 2'b11;

      // Reset state
      repeat (3) @(negedge sysclk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_bcd7", 32'(bcd7), 32'h7F);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // Scan order after release: E,D,B,7 each for 4 cycles
      reset = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge sysclk);
         check("scan_an", 32'(an), 32'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
      end

      // Hex display
      ch[1] = 16'h12AB; sel = 2'd1; dec_mode = 1'b0;
      settle();
      check_window("hex_12ab", 32'h12AB, 1'b0, 1'b0, 16, 1'b0);
      check("hex_ovf", 32'(overflow), 32'd0);

      // Decimal 9999 and busy length
      ch[2] = 16'd9999; sel = 2'd2; dec_mode = 1'b1;
      wait_busy(1'b0, "busy_lo_wait");
      wait_busy(1'b1, "busy_hi_wait");
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge sysclk);
      end
      check("busy_len", 32'(cnt), 32'd16);
      settle();
      check_window("dec_9999", 9999, 1'b1, 1'b0, 16, 1'b0);
      check("dec_9999_ovf", 32'(overflow), 32'd0);

      ch[2] = 16'd10000;
      settle();
      check_window("dec_10000", 10000, 1'b1, 1'b0, 16, 1'b0);
      check("dec_10000_ovf", 32'(overflow), 32'd1);

      // Leading-zero blanking
      ch[0] = 16'd42; sel = 2'd0; blank_lz = 1'b1;
      settle();
      check_window("lz_42", 42, 1'b1, 1'b1, 16, 1'b0);
      check("lz_42_ovf", 32'(overflow), 32'd0);
      ch[0] = 16'd0;
      settle();
      check_window("lz_0", 0, 1'b1, 1'b1, 16, 1'b0);

      // Select change mid-SHIFT does not disturb the running conversion
      ch[0] = 16'd123; ch[3] = 16'd456; blank_lz = 1'b0;
      settle();
      wait_busy(1'b0, "mid_lo_wait");
      wait_busy(1'b1, "mid_hi_wait");
      repeat (4) @(negedge sysclk);
      sel = 2'd3;
      wait_busy(1'b0, "mid_commit_wait");
      repeat (4) @(negedge sysclk);
      check_window("mid_0123", 123, 1'b1, 1'b0, 15, 1'b0);
      repeat (3) @(negedge sysclk);
      check_window("mid_0456", 456, 1'b1, 1'b0, 16, 1'b0);

      // Reset during SHIFT takes effect immediately
      wait_busy(1'b0, "rs_lo_wait");
      wait_busy(1'b1, "rs_hi_wait");
      reset = 1'b0;
      #1;
      check("rs_busy", 32'(busy), 32'd0);
      check("rs_an", 32'(an), 32'hF);
      check("rs_bcd7", 32'(bcd7), 32'h7F);
      check("rs_ovf", 32'(overflow), 32'd0);
      @(negedge sysclk);
      reset = 1'b1;
      @(negedge sysclk);
      check("rs_release_an", 32'(an), 32'hE);

      // Out-of-range select on a 3-channel instance shows zero
      settle();
      check_window("sel_oob", 0, 1'b0, 1'b0, 16, 1'b1);
      check("sel_oob_ovf", 32'(overflow3), 32'd0);

      // Randomised cases
      for (int t = 0; t < 15; t++) begin
         for (int k = 0; k < 4; k++)
            ch[k] = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)]
                                                : 16'($urandom);
         sel      = 2'($urandom_range(0, 3));
         dec_mode = 1'($urandom);
         blank_lz = 1'($urandom);
         settle();
         v = chan_val(int'(sel));
         check_window("rand", v, dec_mode, blank_lz, 16, 1'b0);
         check("rand_ovf", 32'(overflow), 32'(dec_mode && v > 9999));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
